column_render_scheduler: RTL

//  Frame-level sequencer for the vertical-line drawer. For each screen column x = 0..SCREEN_W-1
//  it fetches wall extents from the raycaster (req/valid handshake), then issues up to three

---
 rtl/column_render_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/column_render_scheduler.sv
// Column render scheduler: walks every screen column of a frame, fetches the wall
// extents from the raycaster and issues ceiling / wall / floor draws to the shared
// vertical-line drawer.
module column_render_scheduler #(
    parameter int unsigned SCREEN_W     = 160,
    parameter int unsigned SCREEN_H     = 120,
    parameter logic [17:0] CEIL_COLOUR  = 18'h0_0FFF,
    parameter logic [17:0] FLOOR_COLOUR = 18'h1_5555
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        col_req,
    output logic [7:0]  col_x,
    input  logic        col_valid,
    input  logic [6:0]  wall_top,
    input  logic [6:0]  wall_bot,
    input  logic [17:0] wall_colour,
    output logic        line_start,
    input  logic        line_done,
    output logic [7:0]  line_x,
    output logic [6:0]  line_min_y,
    output logic [6:0]  line_max_y,
    output logic [17:0] line_colour
);

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned C_W = 18;

    localparam logic [X_W-1:0] X_LAST    = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST    = Y_W'(SCREEN_H - 1);
    localparam logic [Y_W-1:0] Y_HALF_LO = Y_W'(SCREEN_H / 2 - 1);
    localparam logic [Y_W-1:0] Y_HALF_HI = Y_W'(SCREEN_H / 2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_CEIL_GO,
        S_CEIL_WAIT,
        S_WALL_GO,
        S_WALL_WAIT,
        S_FLOOR_GO,
        S_FLOOR_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         state;
    logic [Y_W-1:0] top_q;
    logic [Y_W-1:0] bot_q;
    logic [C_W-1:0] colour_q;

    logic [Y_W-1:0] seg_top;
    logic [Y_W-1:0] seg_bot;
    logic [C_W-1:0] seg_colour;
    logic           no_wall;
    logic           has_ceil;
    logic           has_floor;
    logic [Y_W-1:0] ceil_max;
    logic [Y_W-1:0] floor_min;

    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
        return (y > Y_LAST) ? Y_LAST : y;
    endfunction

    // Column geometry: live raycaster data while it is being latched, stored copy afterwards
    always_comb begin
        if (state == S_REQ) begin
            seg_top    = clamp_y(wall_top);
            seg_bot    = clamp_y(wall_bot);
            seg_colour = wall_colour;
        end else begin
            seg_top    = top_q;
            seg_bot    = bot_q;
            seg_colour = colour_q;
        end
        no_wall   = seg_top > seg_bot;
        has_ceil  = no_wall || (seg_top != '0);
        has_floor = no_wall || (seg_bot != Y_LAST);
        ceil_max  = no_wall ? Y_HALF_LO : seg_top - Y_W'(1);
        floor_min = no_wall ? Y_HALF_HI : seg_bot + Y_W'(1);
    end

    // Frame sequencer with registered handshake and drawer outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            col_req     <= 1'b0;
            col_x       <= '0;
            line_start  <= 1'b0;
            line_x      <= '0;
            line_min_y  <= '0;
            line_max_y  <= '0;
            line_colour <= '0;
            top_q       <= '0;
            bot_q       <= '0;
            colour_q    <= '0;
        end else begin
            line_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_REQ;
                        col_x   <= '0;
                        busy    <= 1'b1;
                        col_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (col_valid) begin
                        top_q      <= seg_top;
                        bot_q      <= seg_bot;
                        colour_q   <= seg_colour;
                        col_req    <= 1'b0;
                        line_start <= 1'b1;
                        line_x     <= col_x;
                        if (has_ceil) begin
                            state       <= S_CEIL_GO;
                            line_min_y  <= '0;
                            line_max_y  <= ceil_max;
                            line_colour <= CEIL_COLOUR;
                        end else begin
                            state       <= S_WALL_GO;
                            line_min_y  <= seg_top;
                            line_max_y  <= seg_bot;
                            line_colour <= seg_colour;
                        end
                    end
                end
                S_CEIL_GO: state <= S_CEIL_WAIT;
                S_CEIL_WAIT: begin
                    if (line_done) begin
                        line_start <= 1'b1;
                        if (no_wall) begin
                            state       <= S_FLOOR_GO;
                            line_min_y  <= floor_min;
                            line_max_y  <= Y_LAST;
                            line_colour <= FLOOR_COLOUR;
                        end else begin
                            state       <= S_WALL_GO;
                            line_min_y  <= seg_top;
                            line_max_y  <= seg_bot;
                            line_colour <= seg_colour;
                        end
                    end
                end
                S_WALL_GO: state <= S_WALL_WAIT;
                S_WALL_WAIT: begin
                    if (line_done) begin
                        if (has_floor) begin
                            state       <= S_FLOOR_GO;
                            line_start  <= 1'b1;
                            line_min_y  <= floor_min;
                            line_max_y  <= Y_LAST;
                            line_colour <= FLOOR_COLOUR;
                        end else begin
                            state <= S_NEXT;
                        end
                    end
                end
                S_FLOOR_GO: state <= S_FLOOR_WAIT;
                S_FLOOR_WAIT: begin
                    if (line_done) begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (col_x == X_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= S_REQ;
                        col_x   <= col_x + X_W'(1);
                        col_req <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
